alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational execute-stage ALU among REQS requesters (scalar pipe plus vector lanes) using round-robin arbitration. Each requester presents operands and a 4-bit ALU control code over a valid/ready handshake. The block drives the ALU for one cycle and returns a registered result and flags to the granted requester over a valid/ready response handshake. It traps divide/modulus by zero and never presents them to the ALU. It sits between the issue logic and the ALU instance in the Execute stage.

## Interface
- N, 8, operand/result width (signed)
- REQS, 4, number of requesters (2..8)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  REQS  requester i has an operation pending
- req_ready  out  REQS  one-hot grant; operation accepted at the edge where valid&ready
- req_a  in  REQS*N  operand a of requester i at [i*N +: N]
- req_b  in  REQS*N  operand b of requester i at [i*N +: N]
- req_ctrl  in  REQS*4  ALU code of requester i at [i*4 +: 4]
- rsp_valid  out  REQS  one-hot; response for requester i is present
- rsp_ready  in  REQS  requester i consumes the response
- rsp_result  out  N  shared response data
- rsp_flags  out  4  {neg, zero, carry, overflow}
- rsp_err  out  1  1 = divide/modulus by zero trapped
- alu_a, alu_b  out  N  to ALU operands
- alu_ctrl  out  4  to ALU control
- alu_result  in  N  from ALU
- alu_flags  in  4  from ALU

## Operation
- FSM has three states. IDLE: arbitrate. EXEC: drive the ALU from operand registers. RESP: hold the response.
- IDLE: the winner is the first i with req_valid[i], searched from ptr upward modulo REQS. req_ready[winner] goes high combinationally, and only in IDLE. At that edge the block captures a, b, ctrl, and the id, sets ptr = winner+1 mod REQS, and moves to EXEC. With no valid request it stays in IDLE and ptr is unchanged.
- EXEC: alu_a/alu_b/alu_ctrl come from the operand registers. At the edge the block captures alu_result and alu_flags into the response registers and moves to RESP.
- Trap: if ctrl is 4'b1000 or 4'b0100 and b == 0, EXEC drives the ALU with ctrl 4'b0110 and b = 0. It captures result 0, flags 4'b0100, and rsp_err = 1.
- Outside EXEC, alu_ctrl = 4'b0110 and alu_a = alu_b = 0.
- RESP: rsp_valid[id] = 1, with result, flags, and err stable. On rsp_ready[id] the block returns to IDLE. rsp_ready of other indices is ignored.
- Codes other than the eight defined ones are forwarded unchanged, and the ALU result is returned as-is.

## Timing
- Reset values: state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_err 0. The ALU drive outputs take their idle values.
- Latency: acceptance edge T, result captured at T+1, rsp_valid high during the cycle after T+1.
- Best-case throughput is one operation per 3 cycles (rsp_ready already high).
- A requester may drop req_valid before it is granted, with no effect. Operands must be stable only in the acceptance cycle.
- A new request from the same requester may be presented while it waits for its response. It is not granted until the FSM is back in IDLE, and the earliest grant is the cycle after the response handshake.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0,… No requester waits more than REQS-1 grants.
- Reset asserted mid-operation aborts immediately. The in-flight operation is discarded, with no response.

## Structure
- Package alu_pkg holds the ALU code localparams (ADD 0000, SUB 0001, MUL 0010, OR 0011, MOD 0100, AND 0101, COPY 0110, DIV 1000), the flag bit indices, and the FSM state enum.
- Sub-module rr_arbiter (REQS): inputs are req vector and ptr; outputs are one-hot grant and winner index. It is purely combinational.
- The ALU itself stays outside this block.

## Test plan
- Single request: requester 2 sends ADD, a=5, b=3. Expect req_ready[2] in the same cycle, rsp_valid[2] two cycles later, result 8, flags 0000, err 0.
- Contention: all four requesters hold valid continuously, each with SUB a=i, b=1. Expect grant order 0,1,2,3,0. Each result is i-1, and requester 0 sets neg = 1.
- Div-by-zero: requester 1 sends DIV, a=7, b=0. Expect alu_ctrl never to show 1000 with b=0. Expect result 0, flags 0100, err 1.
- Response backpressure: hold rsp_ready[0] low for 5 cycles while requester 1 is valid. Expect rsp_valid[0] and the data stable throughout and req_ready[1] low. Expect requester 1 to be granted in the cycle after the handshake.
- Reset mid-EXEC: assert rst during EXEC. Expect all outputs at their reset values asynchronously and no rsp_valid afterwards. Expect ptr = 0, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the execute-stage ALU arbiter: ALU codes, flag bit
// positions and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_MOD  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_COPY = 4'b0110;
  localparam logic [3:0] ALU_DIV  = 4'b1000;

  // Flag vector layout {neg, zero, carry, overflow}
  localparam int unsigned FLAG_NEG   = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 0;

  // Flags reported for a trapped divide/modulus by zero: zero only
  localparam logic [3:0] TRAP_FLAGS = 4'(1 << FLAG_ZERO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle of the ALU arbiter.
interface alu_arbiter_if #(
  parameter int N    = 8,
  parameter int REQS = 4
);
  logic [REQS-1:0]   req_valid;
  logic [REQS-1:0]   req_ready;
  logic [REQS*N-1:0] req_a;
  logic [REQS*N-1:0] req_b;
  logic [REQS*4-1:0] req_ctrl;
  logic [REQS-1:0]   rsp_valid;
  logic [REQS-1:0]   rsp_ready;
  logic [N-1:0]      rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo REQS.
module rr_arbiter #(
  parameter int REQS = 4,
  parameter int PW   = $clog2(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [REQS-1:0] grant,
  output logic [PW-1:0]   winner
);

  int unsigned idx;
  logic [PW-1:0] sel;
  logic found;

  // Scan REQS positions starting at ptr and take the first valid one
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned off = 0; off < REQS; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= REQS) idx = idx - REQS;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        winner     = sel;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among REQS
// requesters; one operation in flight, registered response, div/mod-by-zero
// trapped before reaching the ALU.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N    = 8,
  parameter int REQS = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_ctrl,
  input  logic [N-1:0]  alu_result,
  input  logic [3:0]    alu_flags
);

  localparam int PW = $clog2(REQS);

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, id, winner;
  logic [REQS-1:0] grant;
  logic [N-1:0]    op_a, op_b;
  logic [3:0]      op_ctrl;
  logic            trap;
  logic            accept;

  rr_arbiter #(.REQS(REQS)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign trap   = ((op_ctrl == ALU_DIV) || (op_ctrl == ALU_MOD)) && (op_b == '0);
  assign accept = (state == S_IDLE) && (|bus.req_valid);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake strobes and ALU drive
  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_ctrl      = ALU_COPY;
    case (state)
      S_IDLE: begin
        // rst gating keeps the grant low while reset is held with requests pending
        if (!rst) bus.req_ready = grant;
        if (|bus.req_valid) state_nx = S_EXEC;
      end
      S_EXEC: begin
        alu_a    = op_a;
        alu_b    = trap ? '0 : op_b;
        alu_ctrl = trap ? ALU_COPY : op_ctrl;
        state_nx = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[id] = 1'b1;
        if (bus.rsp_ready[id]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture at acceptance, response capture at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      id             <= '0;
      op_a           <= '0;
      op_b           <= '0;
      op_ctrl        <= ALU_COPY;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= bus.req_a[winner*N +: N];
        op_b    <= bus.req_b[winner*N +: N];
        op_ctrl <= bus.req_ctrl[winner*4 +: 4];
        id      <= winner;
        ptr     <= (winner == PW'(REQS-1)) ? '0 : winner + 1'b1;
      end
      if (state == S_EXEC) begin
        bus.rsp_result <= trap ? '0 : alu_result;
        bus.rsp_flags  <= trap ? TRAP_FLAGS : alu_flags;
        bus.rsp_err    <= trap;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_ctrl, alu_flags;

  int tests = 0;
  int fails = 0;
  logic bad_trap_seen = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.N(8), .REQS(4)) bus ();

  alu_arbiter #(.N(8), .REQS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  // Behavioural ALU; div/mod by zero yields a loud pattern
  logic [8:0] w;
  logic [7:0] r;
  logic       c, v;
  always_comb begin
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        w = {1'b0, alu_a} + {1'b0, alu_b}; r = w[7:0]; c = w[8];
        v = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]);
      end
      ALU_SUB: begin
        w = {1'b0, alu_a} - {1'b0, alu_b}; r = w[7:0]; c = w[8];
        v = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]);
      end
      ALU_MUL:  r = 8'($signed(alu_a) * $signed(alu_b));
      ALU_OR:   r = alu_a | alu_b;
      ALU_AND:  r = alu_a & alu_b;
      ALU_COPY: r = alu_a;
      ALU_DIV:  r = (alu_b == 0) ? 8'hAA : 8'($signed(alu_a) / $signed(alu_b));
      ALU_MOD:  r = (alu_b == 0) ? 8'hAA : 8'($signed(alu_a) % $signed(alu_b));
      default:  r = alu_a ^ alu_b;
    endcase
    alu_result = r;
    alu_flags  = {r[7], r == 8'h00, c, v};
    if ((alu_ctrl == ALU_DIV || alu_ctrl == ALU_MOD) && alu_b == 0) alu_flags = 4'b1111;
  end

  always @(negedge clk)
    if ((alu_ctrl == ALU_DIV || alu_ctrl == ALU_MOD) && alu_b == 8'h00) bad_trap_seen = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] ctrl, input logic [7:0] a, input logic [7:0] b);
    bus.req_ctrl[i*4 +: 4] = ctrl;
    bus.req_a[i*8 +: 8]    = a;
    bus.req_b[i*8 +: 8]    = b;
  endtask

  typedef struct {
    int         id;
    logic [3:0] ctrl;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  vec_t vecs[14];

  // One isolated operation: grant, ALU drive, response, handshake
  task automatic do_op(input vec_t t);
    logic trap;
    trap = (t.ctrl == ALU_DIV || t.ctrl == ALU_MOD) && t.b == 8'h00;
    @(negedge clk);
    set_req(t.id, t.ctrl, t.a, t.b);
    bus.req_valid = 4'(1 << t.id);
    #1 chk("grant", bus.req_ready, 32'(1 << t.id));
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    chk("alu_ctrl", alu_ctrl, trap ? ALU_COPY : t.ctrl);
    chk("alu_b", alu_b, trap ? 8'h00 : t.b);
    if (!trap) chk("alu_a", alu_a, t.a);
    chk("rsp_valid_exec", bus.rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, 32'(1 << t.id));
    chk("result", bus.rsp_result, t.res);
    chk("flags", bus.rsp_flags, t.flg);
    chk("err", bus.rsp_err, t.err);
    bus.rsp_ready = 4'(1 << t.id);
    @(posedge clk);
    #1 bus.rsp_ready = '0;
  endtask

  initial begin
    logic [7:0] sub_res[4];
    logic [3:0] sub_flg[4];
    vecs[0]  = '{2, ALU_ADD,  8'h05, 8'h03, 8'h08, 4'b0000, 1'b0};
    vecs[1]  = '{1, ALU_DIV,  8'h07, 8'h00, 8'h00, 4'b0100, 1'b1};
    vecs[2]  = '{3, ALU_MOD,  8'h09, 8'h00, 8'h00, 4'b0100, 1'b1};
    vecs[3]  = '{0, ALU_DIV,  8'd20, 8'h03, 8'h06, 4'b0000, 1'b0};
    vecs[4]  = '{2, ALU_MOD,  8'hF9, 8'h03, 8'hFF, 4'b1000, 1'b0};
    vecs[5]  = '{1, ALU_ADD,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0};
    vecs[6]  = '{3, ALU_ADD,  8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0};
    vecs[7]  = '{0, ALU_SUB,  8'h05, 8'h05, 8'h00, 4'b0100, 1'b0};
    vecs[8]  = '{2, ALU_MUL,  8'h10, 8'h10, 8'h00, 4'b0100, 1'b0};
    vecs[9]  = '{1, ALU_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
    vecs[10] = '{3, ALU_OR,   8'h80, 8'h01, 8'h81, 4'b1000, 1'b0};
    vecs[11] = '{0, ALU_COPY, 8'h42, 8'h99, 8'h42, 4'b0000, 1'b0};
    vecs[12] = '{2, 4'hF,     8'h0F, 8'hFF, 8'hF0, 4'b1000, 1'b0};
    vecs[13] = '{1, ALU_DIV,  8'hF8, 8'h02, 8'hFC, 4'b1000, 1'b0};
    sub_res = '{8'hFF, 8'h00, 8'h01, 8'h02};
    sub_flg = '{4'b1010, 4'b0100, 4'b0000, 4'b0000};

    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_ctrl = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_flags", bus.rsp_flags, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_alu_ctrl", alu_ctrl, ALU_COPY);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) do_op(vecs[i]);

    // Contention: fresh reset so rotation starts at requester 0
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, ALU_SUB, 8'(i), 8'h01);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", bus.req_ready, 32'(1 << (k % 4)));
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rr_rsp_valid", bus.rsp_valid, 32'(1 << (k % 4)));
      chk("rr_result", bus.rsp_result, sub_res[k % 4]);
      chk("rr_flags", bus.rsp_flags, sub_flg[k % 4]);
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '0;

    // Response backpressure on requester 0 with requester 1 waiting
    set_req(0, ALU_ADD, 8'h11, 8'h22);
    bus.req_valid = 4'b0001;
    #1 chk("bp_grant0", bus.req_ready, 32'b0001);
    @(posedge clk);
    #1;
    set_req(1, ALU_SUB, 8'h10, 8'h01);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    chk("bp_exec_ready", bus.req_ready, 0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 32'b0001);
      chk("bp_result", bus.rsp_result, 8'h33);
      chk("bp_flags", bus.rsp_flags, 4'b0000);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 4'b0001;
    @(posedge clk);
    #1 bus.rsp_ready = '0;
    @(negedge clk);
    chk("bp_grant1", bus.req_ready, 32'b0010);
    @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rsp1_valid", bus.rsp_valid, 32'b0010);
    chk("bp_rsp1_result", bus.rsp_result, 8'h0F);
    bus.rsp_ready = 4'b0010;
    @(posedge clk);
    #1 bus.rsp_ready = '0;

    // Reset mid-EXEC: ptr is 2 here, so requester 2 wins first
    @(negedge clk);
    set_req(1, ALU_ADD, 8'h02, 8'h02);
    set_req(2, ALU_ADD, 8'h01, 8'h01);
    bus.req_valid = 4'b0110;
    #1 chk("mr_grant2", bus.req_ready, 32'b0100);
    @(posedge clk);
    @(negedge clk);
    chk("mr_in_exec", alu_ctrl, ALU_ADD);
    rst = 1'b1;
    #1;
    chk("mr_req_ready", bus.req_ready, 0);
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_result", bus.rsp_result, 0);
    chk("mr_flags", bus.rsp_flags, 0);
    chk("mr_err", bus.rsp_err, 0);
    chk("mr_alu_ctrl", alu_ctrl, ALU_COPY);
    chk("mr_alu_a", alu_a, 0);
    chk("mr_alu_b", alu_b, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_no_rsp", bus.rsp_valid, 0);
    chk("mr_grant_lowest", bus.req_ready, 32'b0010);
    bus.req_valid = '0;
    @(negedge clk);
    chk("mr_still_no_rsp", bus.rsp_valid, 0);

    chk("no_trap_to_alu", bad_trap_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
